// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - multi-channel arbiter feeding a byte-serial little-endian RAM controller
// Optional MEM_ARB_RR_EN selects round-robin arbitration; default is fixed priority (ch0 highest).
module mem_arbiter_ctrl #(
  parameter int                NUM_CH     = 2,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                LEN_W      = 3,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = 2'b10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*LEN_W-1:0]  req_len,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        done,
  output logic [DATA_W-1:0]        rdata,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr
);
  localparam int BYTES = DATA_W / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

  state_e            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [NUM_CH-1:0] done_q;
  logic [7:0]        mem_dout_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic              mem_wr_q;
`ifdef MEM_ARB_RR_EN
  logic [CH_W-1:0]   rr_ptr_q;
`endif

  logic [NUM_CH-1:0] elig;
  logic              grant_vld;
  logic              grant_wr;
  logic [CH_W-1:0]   grant_ch;
  logic [LEN_W-1:0]  grant_len_raw;
  logic [LEN_W-1:0]  grant_len;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;
  int                base;

  always_comb begin
    elig = req_valid & ~done_q & ~(FLUSH_MASK & ~req_wr & {NUM_CH{flush}});
`ifdef MEM_ARB_RR_EN
    base = int'(rr_ptr_q);
`else
    base = NUM_CH - 1;
`endif
    grant_vld     = 1'b0;
    grant_wr      = 1'b0;
    grant_ch      = '0;
    grant_len_raw = '0;
    grant_addr    = '0;
    grant_wdata   = '0;
    // Search slot k holds channel (base+k) mod NUM_CH; walking k downwards lets slot 1 win last.
    for (int k = NUM_CH; k >= 1; k--) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (elig[i] && i == (base + k) % NUM_CH) begin
          grant_vld     = 1'b1;
          grant_wr      = req_wr[i];
          grant_ch      = CH_W'(i);
          grant_len_raw = req_len[i*LEN_W +: LEN_W];
          grant_addr    = req_addr[i*ADDR_W +: ADDR_W];
          grant_wdata   = req_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
    grant_len = (grant_len_raw == '0 || grant_len_raw > LEN_W'(BYTES)) ? LEN_W'(BYTES) : grant_len_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      mem_dout_q <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q   <= '0;
`endif
    end else if (rdy) begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            ch_q    <= grant_ch;
            len_q   <= grant_len;
            cnt_q   <= '0;
            mem_a_q <= grant_addr;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q <= grant_ch;
`endif
            if (grant_wr) begin
              mem_wr_q   <= 1'b1;
              mem_dout_q <= grant_wdata[7:0];
              wdata_q    <= grant_wdata >> 8;
              state_q    <= S_WRITE;
            end else begin
              mem_wr_q <= 1'b0;
              rdata_q  <= '0;
              state_q  <= S_READ;
            end
          end
        end
        S_READ: begin
          if (flush && FLUSH_MASK[ch_q]) begin
            state_q <= S_IDLE;
            mem_a_q <= '0;
            rdata_q <= '0;
          end else begin
            if (cnt_q + LEN_W'(1) < len_q) mem_a_q <= mem_a_q + ADDR_W'(1);
            // RAM answers one edge late, so the byte arriving now belongs to step cnt-1.
            for (int b = 0; b < BYTES; b++) begin
              if (cnt_q != '0 && LEN_W'(b) == cnt_q - LEN_W'(1)) rdata_q[8*b +: 8] <= mem_din;
            end
            if (cnt_q == len_q) begin
              done_q[ch_q] <= 1'b1;
              mem_a_q      <= '0;
              state_q      <= S_IDLE;
            end
            cnt_q <= cnt_q + LEN_W'(1);
          end
        end
        S_WRITE: begin
          if (cnt_q + LEN_W'(1) < len_q) begin
            mem_a_q    <= mem_a_q + ADDR_W'(1);
            mem_dout_q <= wdata_q[7:0];
            wdata_q    <= wdata_q >> 8;
            cnt_q      <= cnt_q + LEN_W'(1);
          end else begin
            mem_wr_q     <= 1'b0;
            mem_dout_q   <= '0;
            mem_a_q      <= '0;
            done_q[ch_q] <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done     = done_q;
  assign rdata    = rdata_q;
  assign mem_dout = mem_dout_q;
  assign mem_a    = mem_a_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb/tb_mem_arbiter_ctrl.sv - scoreboard bench for mem_arbiter_ctrl with a registered RAM model
// Honours MEM_ARB_RR_EN in its grant-order model.
module tb_mem_arbiter_ctrl;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 3;
  localparam int BYTES  = 4;

  logic                     clk = 1'b0;
  logic                     rst, rdy, flush;
  logic [NUM_CH-1:0]        req_valid, req_wr, done;
  logic [NUM_CH*LEN_W-1:0]  req_len;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]        rdata;
  logic [7:0]               mem_din = 8'h00;
  logic [7:0]               mem_dout;
  logic [ADDR_W-1:0]        mem_a;
  logic                     mem_wr;

  always #5 clk = ~clk;

  mem_arbiter_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FLUSH_MASK(2'b10)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .req_valid(req_valid), .req_wr(req_wr), .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .rdata(rdata), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { int ch; bit wr; int len; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int done_edge; } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          rdy_edges = 0;
  bit          last_edge_rdy = 1'b0;
  int          model_last = 0;
  exp_t        exp_q[$];
  wr_t         wr_log[$];
  logic [7:0]  ram_pre [logic [31:0]];
  bit          r_wr    [NUM_CH];
  int          r_len   [NUM_CH];
  logic [31:0] r_addr  [NUM_CH];
  logic [31:0] r_wdata [NUM_CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_pre.exists(a)) return ram_pre[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ {a[1:0], a[23:18]} ^ 8'h5A;
  endfunction

  // Registered RAM sharing the global enable; reads never see writes so read data is address-only.
  always @(posedge clk) begin
    last_edge_rdy = rdy && !rst;
    if (rdy && !rst) begin
      rdy_edges++;
      mem_din <= ram_rd(mem_a);
      if (mem_wr) wr_log.push_back({mem_a, mem_dout});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && last_edge_rdy && done != '0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (done[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done ch=%0d actual=1 required=0", i);
          end else begin
            e = exp_q.pop_front();
            check("done_ch", i, e.ch);
            check("done_edge", rdy_edges, e.done_edge);
            if (e.wr) begin
              check("wr_count", wr_log.size(), e.len);
              for (int k = 0; k < e.len && k < wr_log.size(); k++)
                check("wr_byte", {wr_log[k].a, wr_log[k].d}, {e.addr + 32'(k), e.wdata[8*k +: 8]});
            end else begin
              check("rdata", rdata, e.rdata);
              check("rd_no_writes", wr_log.size(), 0);
            end
          end
          wr_log.delete();
        end
      end
    end
  end

  task automatic set_ch(input int c, input bit wr, input int len, input logic [31:0] addr, input logic [31:0] wd);
    r_wr[c] = wr;
    r_len[c] = len;
    r_addr[c] = addr;
    r_wdata[c] = wd;
    req_wr[c] = wr;
    req_len[c*LEN_W +: LEN_W] = LEN_W'(len);
    req_addr[c*ADDR_W +: ADDR_W] = addr;
    req_wdata[c*DATA_W +: DATA_W] = wd;
  endtask

  // Requests in mask are all raised together and held, so the service order is the arbitration order.
  task automatic push_model(input logic [1:0] mask);
    int   t;
    int   order[$];
    exp_t e;
    t = rdy_edges + 1;
`ifdef MEM_ARB_RR_EN
    for (int k = 1; k <= NUM_CH; k++) if (mask[(model_last + k) % NUM_CH]) order.push_back((model_last + k) % NUM_CH);
`else
    for (int c = 0; c < NUM_CH; c++) if (mask[c]) order.push_back(c);
`endif
    foreach (order[j]) begin
      e.ch = order[j];
      e.wr = r_wr[e.ch];
      e.len = (r_len[e.ch] == 0 || r_len[e.ch] > BYTES) ? BYTES : r_len[e.ch];
      e.addr = r_addr[e.ch];
      e.wdata = r_wdata[e.ch];
      e.rdata = 32'h0;
      for (int k = 0; k < e.len; k++) e.rdata[8*k +: 8] = ram_rd(e.addr + 32'(k));
      e.done_edge = t + (e.wr ? e.len : e.len + 1);
      t = e.done_edge + 1;
      model_last = e.ch;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_round(input bit stall, input bit fl);
    int cyc;
    cyc = 0;
    while (req_valid != '0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      req_valid = req_valid & ~done;
      rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      flush = fl ? ($urandom_range(0, 4) == 0) : 1'b0;
    end
    if (req_valid != '0) begin
      checks++;
      errors++;
      $display("FAIL round_timeout actual=%b required=00", req_valid);
      req_valid = '0;
    end
    rdy = 1'b1;
    flush = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [1:0] mask, input bit stall, input bit fl);
    push_model(mask);
    req_valid = mask;
    wait_round(stall, fl);
  endtask

  initial begin
    logic [1:0]  m;
    bit          fl;
    logic [31:0] a;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    req_valid = '0; req_wr = '0; req_len = '0; req_addr = '0; req_wdata = '0;
    ram_pre[32'h100] = 8'h11; ram_pre[32'h101] = 8'h22; ram_pre[32'h102] = 8'h33; ram_pre[32'h103] = 8'h44;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_dout", mem_dout, 0);

    set_ch(1, 0, 4, 32'h100, 32'h0);
    run(2'b10, 0, 0);
    set_ch(0, 1, 2, 32'h30000, 32'h0000ABCD);
    run(2'b01, 0, 0);
    set_ch(0, 0, 1, 32'h44, 32'h0);
    set_ch(1, 0, 4, 32'h200, 32'h0);
    run(2'b11, 0, 0);

    // Stall three cycles in the middle of a 4-byte write; the bus must hold byte 1.
    set_ch(0, 1, 4, 32'h2000, 32'hDEADBEEF);
    push_model(2'b01);
    req_valid = 2'b01;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_mem_a", mem_a, 32'h2001);
      check("stall_mem_dout", mem_dout, 8'hBE);
      check("stall_mem_wr", mem_wr, 1);
    end
    wait_round(0, 0);

    // Flush aborts a flushable read mid-transfer; no completion may follow.
    set_ch(1, 0, 4, 32'h500, 32'h0);
    req_valid = 2'b10;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    req_valid = '0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_mem_a", mem_a, 0);
    check("flush_rdata", rdata, 0);
    check("flush_done", done, 0);
    model_last = 1;
    repeat (6) @(negedge clk);
    set_ch(0, 0, 3, 32'h600, 32'h0);
    run(2'b01, 0, 0);

    // Flush held in IDLE keeps a flushable read from being accepted.
    set_ch(1, 0, 2, 32'h700, 32'h0);
    flush = 1'b1;
    req_valid = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check("flush_idle_mem_a", mem_a, 0);
    end
    flush = 1'b0;
    push_model(2'b10);
    wait_round(0, 0);

    set_ch(0, 0, 0, 32'hFFFF_FFFE, 32'h0);
    run(2'b01, 0, 0);

    for (int n = 0; n < 40; n++) begin
      m = 2'($urandom_range(1, 3));
      fl = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE - 32'($urandom_range(0, 2)) : 32'($urandom());
        set_ch(c, ($urandom_range(0, 1) == 1) || (fl && c == 1), $urandom_range(0, 7), a, 32'($urandom()));
      end
      run(m, $urandom_range(0, 1) == 1, fl);
    end
    check("scoreboard_empty", exp_q.size(), 0);

    // Reset in the middle of a read returns every output to its reset value.
    set_ch(0, 0, 4, 32'h900, 32'h0);
    req_valid = 2'b01;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("midrst_mem_a", mem_a, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
